fma16_result_retire: RTL and testbench

- Downstream stage of the fma16 special-case stage. Captures each final result and its exception flags into a small FIFO with a valid/ready handshake.
- Masks flags that the special-case override makes meaningless.
- Accumulates sticky IEEE flags and counts retired operations for the surrounding testbench and CSR logic.

---
 rtl/fma16_result_retire.sv | 77 +++++++
 tb/tb_fma16_result_retire.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fma16_result_retire.sv
// fma16_result_retire: buffers fma16 results with masked flags, accumulates sticky flags and counts retired ops
module fma16_result_retire #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      result,
    input  logic             invalid,
    input  logic             overflow,
    input  logic             underflow,
    input  logic             inexact,
    input  logic             special_case,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       sticky_flags,
    input  logic             flags_clear,
    output logic [CNT_W-1:0] retired_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [15:0]      res_q [DEPTH];
    logic [3:0]       flg_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [3:0]       sticky_q, sticky_d, flags_in;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             push, pop;

    // Handshakes, flag masking and next-state for pointers, occupancy, sticky flags and counter
    always_comb begin
        in_ready      = count_q != FULL;
        out_valid     = count_q != '0;
        push          = in_valid & in_ready;
        pop           = out_valid & out_ready;
        flags_in      = {invalid, overflow & ~special_case, underflow & ~special_case, inexact & ~special_case};
        out_result    = out_valid ? res_q[rd_ptr_q] : 16'h0;
        out_flags     = out_valid ? flg_q[rd_ptr_q] : 4'h0;
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d       = (push & ~pop) ? count_q + 1'b1 : (pop & ~push) ? count_q - 1'b1 : count_q;
        sticky_d      = (flags_clear ? 4'h0 : sticky_q) | (pop ? out_flags : 4'h0);
        retired_d     = pop ? retired_q + 1'b1 : retired_q;
        sticky_flags  = sticky_q;
        retired_count = retired_q;
    end

    // Control state; reset empties the FIFO so stale storage is never visible
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sticky_q  <= '0;
            retired_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sticky_q  <= sticky_d;
            retired_q <= retired_d;
        end
    end

    // Entry storage, written at the write pointer on each accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            res_q[wr_ptr_q] <= result;
            flg_q[wr_ptr_q] <= flags_in;
        end
    end
endmodule

// File: tb/tb_fma16_result_retire.sv
// tb_fma16_result_retire: queue-model bench with directed vectors for fma16_result_retire
module tb_fma16_result_retire;
    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0, in_ready;
    logic [15:0] result = 0;
    logic        invalid = 0, overflow = 0, underflow = 0, inexact = 0, special_case = 0;
    logic        out_valid, out_ready = 0;
    logic [15:0] out_result;
    logic [3:0]  out_flags, sticky_flags;
    logic        flags_clear = 0;
    logic [15:0] retired_count;

    int checks = 0, errors = 0;
    bit en = 0;

    logic [19:0] mq[$];
    logic [3:0]  m_sticky = 0;
    logic [15:0] m_cnt = 0;

    fma16_result_retire #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .invalid(invalid), .overflow(overflow), .underflow(underflow),
        .inexact(inexact), .special_case(special_case), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .flags_clear(flags_clear), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a bounded queue of {result, flags}; sticky clears before the retiring op is merged
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_sticky = 0;
            m_cnt = 0;
        end else begin
            bit do_pop, do_push;
            do_pop  = (mq.size() != 0) && out_ready;
            do_push = in_valid && (mq.size() != 2);
            if (flags_clear) m_sticky = 0;
            if (do_pop) begin
                m_sticky = m_sticky | mq[0][3:0];
                m_cnt++;
                void'(mq.pop_front());
            end
            if (do_push)
                mq.push_back({result, invalid, overflow & ~special_case,
                              underflow & ~special_case, inexact & ~special_case});
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (en) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(mq.size() != 2));
            chk("out_result", 32'(out_result), mq.size() != 0 ? 32'(mq[0][19:4]) : 32'h0);
            chk("out_flags", 32'(out_flags), mq.size() != 0 ? 32'(mq[0][3:0]) : 32'h0);
            chk("sticky", 32'(sticky_flags), 32'(m_sticky));
            chk("retired", 32'(retired_count), 32'(m_cnt));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [4:0] f);
        in_valid = v;
        result = r;
        {invalid, overflow, underflow, inexact, special_case} = f;
    endtask

    initial begin
        int n;
        cyc(); cyc();
        reset = 0;
        en = 1;
        cyc();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_retired", 32'(retired_count), 0);

        out_ready = 1;
        drive(1, 16'h3C00, 5'b00000); cyc();
        drive(0, 0, 0);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_result", 32'(out_result), 32'h3C00);
        chk("t1_flags", 32'(out_flags), 0);
        cyc();
        chk("t1_retired", 32'(retired_count), 1);
        chk("t1_sticky", 32'(sticky_flags), 0);

        drive(1, 16'h7E00, 5'b11011); cyc();
        drive(0, 0, 0);
        chk("t2_flags", 32'(out_flags), 32'b1000);
        cyc();
        chk("t2_sticky", 32'(sticky_flags), 32'b1000);

        flags_clear = 1; cyc(); flags_clear = 0;
        chk("clr_sticky", 32'(sticky_flags), 0);
        drive(1, 16'h7BFF, 5'b01010); cyc();
        drive(1, 16'h0001, 5'b00110);
        chk("t3_flags_a", 32'(out_flags), 32'b0101);
        cyc();
        drive(0, 0, 0);
        chk("t3_flags_b", 32'(out_flags), 32'b0011);
        chk("t3_result_b", 32'(out_result), 32'h0001);
        cyc();
        chk("t3_sticky", 32'(sticky_flags), 32'b0111);

        drive(1, 16'h7E00, 5'b10001); cyc();
        drive(0, 0, 0);
        flags_clear = 1; cyc();
        chk("t5_clear_retire", 32'(sticky_flags), 32'b1000);
        cyc(); flags_clear = 0;
        chk("t5_clear_only", 32'(sticky_flags), 0);
        chk("t5_retired", 32'(retired_count), 5);

        out_ready = 0;
        drive(1, 16'h1111, 5'b00010); cyc();
        drive(1, 16'h2222, 5'b00100); cyc();
        drive(1, 16'h3333, 5'b01000);
        chk("t4_full", 32'(in_ready), 0);
        chk("t4_head", 32'(out_result), 32'h1111);
        cyc();
        chk("t4_stable", 32'(out_result), 32'h1111);
        chk("t4_held", 32'(in_ready), 0);
        out_ready = 1; cyc();
        chk("t4_second", 32'(out_result), 32'h2222);
        cyc();
        drive(0, 0, 0);
        chk("t4_third", 32'(out_result), 32'h3333);
        cyc();
        chk("t4_retired", 32'(retired_count), 8);
        chk("t4_empty", 32'(out_valid), 0);

        n = 0;
        while (m_cnt != 16'hFFFF && n < 70000) begin
            drive(1, 16'(n * 7 + 3), 5'(n));
            cyc();
            n++;
        end
        if (m_cnt != 16'hFFFF) chk("bulk_timeout", 32'(n), 0);
        out_ready = 0;
        drive(1, 16'hABCD, 5'b01110); cyc();
        drive(0, 0, 0);
        chk("t6_pre_retired", 32'(retired_count), 32'hFFFF);
        chk("t6_pre_full", 32'(in_ready), 0);
        reset = 1; cyc(); reset = 0;
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_ready", 32'(in_ready), 1);
        chk("t6_retired", 32'(retired_count), 0);
        chk("t6_sticky", 32'(sticky_flags), 0);
        chk("t6_result", 32'(out_result), 0);
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
